// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadows dest regs of EX and FWD_DEPTH later stages.
// Latency: stall is combinational from ID inputs; fwd_sel is combinational from registered EX state.
// Backpressure: stall holds PC and IF/ID for one cycle and sends a bubble into EX; back end never stalls.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [CNT_W-1:0]              stall_count
);

  // Entry j describes the instruction j stages past EX (entry 0 is EX itself).
  logic [REG_ADDR_W-1:0]         e_rd [0:FWD_DEPTH];
  logic [FWD_DEPTH:0]            e_vld;
  logic [FWD_DEPTH:0]            e_rw;
  logic [FWD_DEPTH:0]            e_wr;
  // Only the EX entry needs mem_read: a load past EX forwards like any other result.
  logic                          e0_mr;
  logic [NUM_SRC*REG_ADDR_W-1:0] e0_rs;
  logic [NUM_SRC-1:0]            e0_used;

  logic hazard;
  logic load_id;

  // An entry produces a forwardable value only if it is real, writes, and targets a non-x0 register.
  always_comb begin
    e_wr = '0;
    for (int j = 0; j <= FWD_DEPTH; j++) begin
      e_wr[j] = e_vld[j] & e_rw[j] & (e_rd[j] != '0);
    end
  end

  // Load-use: an ID source that really reads the register a load in EX is about to produce.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
          (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == e_rd[0]) && e_wr[0] && e0_mr) begin
        hazard = 1'b1;
      end
    end
  end

  // flush wins over stall: a killed instruction never needs to wait for its operands.
  assign stall   = id_valid & ~flush & hazard;
  assign load_id = id_valid & ~flush & ~stall;

  // Shift the shadow pipeline every edge; EX takes the ID instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld   <= '0;
      e_rw    <= '0;
      e0_mr   <= 1'b0;
      e0_rs   <= '0;
      e0_used <= '0;
      for (int j = 0; j <= FWD_DEPTH; j++) begin
        e_rd[j] <= '0;
      end
    end else begin
      e_vld   <= {e_vld[FWD_DEPTH-1:0], load_id};
      e_rw    <= {e_rw[FWD_DEPTH-1:0], load_id & id_reg_write};
      e0_mr   <= load_id & id_mem_read;
      e0_used <= load_id ? id_rs_used : '0;
      e0_rs   <= id_rs;
      e_rd[0] <= id_rd;
      for (int j = 1; j <= FWD_DEPTH; j++) begin
        e_rd[j] <= e_rd[j-1];
      end
    end
  end

  // Per-source select; scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (e_vld[0] && e0_used[i] && (e0_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
        for (int j = FWD_DEPTH; j >= 1; j--) begin
          if (e_wr[j] && (e_rd[j] == e0_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_DEPTH + 1 - j);
          end
        end
      end
    end
  end

  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance plus a FWD_DEPTH=3/NUM_SRC=3/CNT_W=4 instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, away from the rising edge.
// Expected values are hand-derived from the instruction sequences issued in each task.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Default-parameter instance signals.
  logic        a_valid;
  logic [9:0]  a_rs;
  logic [1:0]  a_used;
  logic [4:0]  a_rd;
  logic        a_rw;
  logic        a_mr;
  logic        a_fl;
  logic        a_stall;
  logic [3:0]  a_sel;
  logic [15:0] a_cnt;

  // Wide instance signals.
  logic        b_valid;
  logic [14:0] b_rs;
  logic [2:0]  b_used;
  logic [4:0]  b_rd;
  logic        b_rw;
  logic        b_mr;
  logic        b_fl;
  logic        b_stall;
  logic [5:0]  b_sel;
  logic [3:0]  b_cnt;

  fwd_hazard_unit u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(a_valid), .id_rs(a_rs), .id_rs_used(a_used),
    .id_rd(a_rd), .id_reg_write(a_rw), .id_mem_read(a_mr), .flush(a_fl),
    .stall(a_stall), .fwd_sel(a_sel), .stall_count(a_cnt)
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(3), .FWD_DEPTH(3), .SEL_W(2), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_rs(b_rs), .id_rs_used(b_used),
    .id_rd(b_rd), .id_reg_write(b_rw), .id_mem_read(b_mr), .flush(b_fl),
    .stall(b_stall), .fwd_sel(b_sel), .stall_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one instruction to u0's ID stage on the falling edge.
  task automatic ia(input logic v, input logic [4:0] rd, input logic [4:0] r0, input logic [4:0] r1,
                    input logic [1:0] u, input logic rw, input logic mr, input logic fl);
    @(negedge clk);
    a_valid = v; a_rd = rd; a_rs = {r1, r0}; a_used = u; a_rw = rw; a_mr = mr; a_fl = fl;
    #1;
  endtask

  task automatic nop_a();
    ia(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Present one instruction to u1's ID stage on the falling edge.
  task automatic ib(input logic v, input logic [4:0] rd, input logic [4:0] r0, input logic [4:0] r1,
                    input logic [4:0] r2, input logic [2:0] u, input logic rw, input logic mr);
    @(negedge clk);
    b_valid = v; b_rd = rd; b_rs = {r2, r1, r0}; b_used = u; b_rw = rw; b_mr = mr; b_fl = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 0; a_rs = 0; a_used = 0; a_rd = 0; a_rw = 0; a_mr = 0; a_fl = 0;
    b_valid = 0; b_rs = 0; b_used = 0; b_rd = 0; b_rw = 0; b_mr = 0; b_fl = 0;
    #2;
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", a_stall); end
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL rst_sel got=%h exp=0", a_sel); end
    total++; if (a_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    @(negedge clk); rst_n = 1'b1;
    ia(1, 5'd8, 5'd2, 5'd0, 2'b01, 1, 1, 0);       // lw x8,0(x2)
    ia(1, 5'd10, 5'd8, 5'd1, 2'b11, 1, 0, 0);      // add x10,x8,x1
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall1 got=%b exp=1", a_stall); end
    ia(1, 5'd10, 5'd8, 5'd1, 2'b11, 1, 0, 0);      // held during stall
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL rst_pre_cnt got=%0d exp=1", a_cnt); end
    ia(1, 5'd9, 5'd10, 5'd0, 2'b01, 1, 1, 0);      // lw x9,0(x10)
    ia(1, 5'd11, 5'd9, 5'd0, 2'b01, 1, 0, 0);      // addi x11,x9
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall2 got=%b exp=1", a_stall); end
    total++; if (a_sel !== 4'b0010) begin bad++; $display("FAIL rst_pre_sel got=%b exp=0010", a_sel); end
    #1; rst_n = 1'b0; #1;
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", a_stall); end
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL rst_mid_sel got=%h exp=0", a_sel); end
    total++; if (a_cnt !== 16'h0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", a_cnt); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL rst_rel_sel got=%h exp=0", a_sel); end
    ia(1, 5'd13, 5'd1, 5'd2, 2'b11, 1, 0, 0);      // addi x11,x9 entered EX with empty history
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL rst_edge_sel got=%h exp=0", a_sel); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_edge_stall got=%b exp=0", a_stall); end
    nop_a(); nop_a(); nop_a();
  endtask

  task automatic test_back_to_back();
    ia(1, 5'd5, 5'd1, 5'd2, 2'b11, 1, 0, 0);       // add x5,x1,x2
    ia(1, 5'd6, 5'd5, 5'd5, 2'b11, 1, 0, 0);       // sub x6,x5,x5
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", a_stall); end
    ia(1, 5'd11, 5'd5, 5'd0, 2'b11, 1, 0, 0);      // or x11,x5,x0
    total++; if (a_sel !== 4'b1010) begin bad++; $display("FAIL b2b_dist1 got=%b exp=1010", a_sel); end
    ia(1, 5'd12, 5'd5, 5'd5, 2'b11, 1, 0, 0);      // and x12,x5,x5
    total++; if (a_sel !== 4'b0001) begin bad++; $display("FAIL b2b_dist2 got=%b exp=0001", a_sel); end
    nop_a();
    total++; if (a_sel !== 4'b0000) begin bad++; $display("FAIL b2b_dist3 got=%b exp=0000", a_sel); end
    ia(1, 5'd7, 5'd3, 5'd4, 2'b11, 1, 0, 0);       // add x7,x3,x4
    ia(1, 5'd7, 5'd1, 5'd2, 2'b11, 1, 0, 0);       // add x7,x1,x2
    ia(1, 5'd14, 5'd7, 5'd7, 2'b11, 1, 0, 0);      // add x14,x7,x7
    nop_a();
    total++; if (a_sel !== 4'b1010) begin bad++; $display("FAIL youngest got=%b exp=1010", a_sel); end
    nop_a(); nop_a(); nop_a();
  endtask

  task automatic test_load_use();
    ia(1, 5'd8, 5'd2, 5'd0, 2'b01, 1, 1, 0);       // lw x8,0(x2)
    ia(1, 5'd9, 5'd8, 5'd1, 2'b11, 1, 0, 0);       // add x9,x8,x1
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", a_stall); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL lu_cnt0 got=%0d exp=0", a_cnt); end
    ia(1, 5'd9, 5'd8, 5'd1, 2'b11, 1, 0, 0);       // held; bubble now in EX
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", a_stall); end
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL lu_bubble_sel got=%h exp=0", a_sel); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=1", a_cnt); end
    nop_a();
    total++; if (a_sel !== 4'b0001) begin bad++; $display("FAIL lu_sel got=%b exp=0001", a_sel); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_nostall got=%b exp=0", a_stall); end
    nop_a(); nop_a(); nop_a();
  endtask

  task automatic test_x0_unused();
    ia(1, 5'd0, 5'd2, 5'd0, 2'b01, 1, 1, 0);       // lw x0,0(x2)
    ia(1, 5'd15, 5'd0, 5'd0, 2'b11, 1, 0, 0);      // add x15,x0,x0
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", a_stall); end
    nop_a();
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL x0_sel got=%h exp=0", a_sel); end
    ia(1, 5'd14, 5'd2, 5'd0, 2'b01, 1, 1, 0);      // lw x14,0(x2)
    ia(1, 5'd15, 5'd14, 5'd14, 2'b00, 1, 0, 0);    // lui x15 with stale rs fields = x14
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL unused_stall got=%b exp=0", a_stall); end
    nop_a();
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL unused_sel got=%h exp=0", a_sel); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL unused_cnt got=%0d exp=1", a_cnt); end
    nop_a(); nop_a(); nop_a();
  endtask

  task automatic test_flush();
    ia(1, 5'd8, 5'd2, 5'd0, 2'b01, 1, 1, 0);       // lw x8,0(x2)
    ia(1, 5'd9, 5'd8, 5'd1, 2'b11, 1, 0, 1);       // add x9,x8,x1 killed by flush
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", a_stall); end
    ia(1, 5'd10, 5'd9, 5'd9, 2'b11, 1, 0, 0);      // add x10,x9,x9
    nop_a();
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL flush_bubble got=%b exp=0000", a_sel); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL flush_cnt got=%0d exp=1", a_cnt); end
    nop_a(); nop_a(); nop_a();
  endtask

  task automatic test_depth3();
    ib(1, 5'd5, 5'd1, 5'd2, 5'd0, 3'b011, 1, 0);   // add x5
    ib(1, 5'd20, 5'd1, 5'd0, 5'd0, 3'b001, 1, 0);  // writes x20
    ib(1, 5'd21, 5'd1, 5'd0, 5'd0, 3'b001, 1, 0);  // writes x21
    ib(1, 5'd22, 5'd5, 5'd21, 5'd20, 3'b111, 1, 0);
    ib(0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0);
    total++; if (b_sel !== 6'b101101) begin bad++; $display("FAIL depth3_sel got=%b exp=101101", b_sel); end
    ib(0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0);
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 20; k++) begin
      ib(1, 5'd8, 5'd2, 5'd0, 5'd0, 3'b001, 1, 1);  // lw x8
      ib(1, 5'd9, 5'd8, 5'd0, 5'd0, 3'b001, 1, 0);  // use x8
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL sat_stall k=%0d got=%b exp=1", k, b_stall); end
      ib(1, 5'd9, 5'd8, 5'd0, 5'd0, 3'b001, 1, 0);  // held
      total++;
      if (b_cnt !== ((k < 15) ? 4'(k) : 4'd15)) begin
        bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, b_cnt, (k < 15) ? k : 15);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_depth3();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
